// File: rtl/uart_pkg.sv
// Shared types and byte constants for the UART receive framing path.
package uart_pkg;

  typedef enum logic [1:0] {HUNT, BODY, CR_SEEN, HOLD} framer_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_TIMEOUT, ERR_BREAK} frame_err_t;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] UART_SYNC = 8'hAA;

endpackage

// File: rtl/uart_idle_timer.sv
// Idle counter: pulses tc on the enabled cycle where the count reaches CYCLES-1.
module uart_idle_timer #(
  parameter int CYCLES = 10420
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  // A clear in the same cycle suppresses the pulse: activity always restarts the window.
  assign tc = enable && !clear && (cnt == CW'(CYCLES-1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             cnt <= '0;
    else if (clear || tc)    cnt <= '0;
    else if (enable)         cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_framer.sv
// Hunts for a sync byte, collects payload up to CR LF / break / overflow / idle
// timeout, and holds the finished frame under a valid/ready handshake.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int         MAX_BYTES      = 32,
  parameter logic [7:0] SYNC_BYTE      = UART_SYNC,
  parameter int         TIMEOUT_CYCLES = 10420
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_break,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic [MAX_BYTES*8-1:0]         frame_data,
  output logic [$clog2(MAX_BYTES+1)-1:0] frame_len,
  output logic [1:0]                     frame_err,
  output logic [7:0]                     drop_count
);

  localparam int LW = $clog2(MAX_BYTES+1);
  localparam int IW = $clog2(MAX_BYTES);

  framer_state_t state_q, state_d;
  frame_err_t    err_q, err_d;
  logic [LW-1:0] len_q, len_d;
  logic [0:MAX_BYTES-1][7:0] buf_q;
  logic          clr_buf, we0, we1, drop_inc, tmo;
  logic [7:0]    b0;
  logic [IW-1:0] idx0, idx1;

  uart_idle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (rx_valid),
    .enable ((state_q == BODY) || (state_q == CR_SEEN)),
    .tc     (tmo)
  );

  assign idx0 = len_q[IW-1:0];
  assign idx1 = IW'(len_q + LW'(1));

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    len_d    = len_q;
    clr_buf  = 1'b0;
    we0      = 1'b0;
    we1      = 1'b0;
    b0       = rx_data;
    drop_inc = 1'b0;
    case (state_q)
      HUNT: if (rx_valid && rx_data == SYNC_BYTE) begin
        state_d = BODY; len_d = '0; clr_buf = 1'b1;
      end
      BODY: begin
        if (rx_break) begin
          state_d = HOLD; err_d = ERR_BREAK;
        end else if (rx_valid) begin
          if (rx_data == ASCII_CR) state_d = CR_SEEN;
          else if (len_q == LW'(MAX_BYTES)) begin
            state_d = HOLD; err_d = ERR_OVF;
          end else begin
            we0 = 1'b1; len_d = len_q + LW'(1);
          end
        end else if (tmo) begin
          state_d = HOLD; err_d = ERR_TIMEOUT;
        end
      end
      CR_SEEN: begin
        // The held CR becomes data unless an LF follows; a second CR keeps one pending.
        b0 = ASCII_CR;
        if (rx_break) begin
          state_d = HOLD; err_d = ERR_BREAK;
        end else if (rx_valid) begin
          if (rx_data == ASCII_LF) begin
            state_d = HOLD; err_d = ERR_NONE;
          end else if (len_q == LW'(MAX_BYTES)) begin
            state_d = HOLD; err_d = ERR_OVF;
          end else if (rx_data == ASCII_CR) begin
            we0 = 1'b1; len_d = len_q + LW'(1);
          end else if (len_q == LW'(MAX_BYTES-1)) begin
            we0 = 1'b1; len_d = LW'(MAX_BYTES); state_d = HOLD; err_d = ERR_OVF;
          end else begin
            we0 = 1'b1; we1 = 1'b1; len_d = len_q + LW'(2); state_d = BODY;
          end
        end else if (tmo) begin
          state_d = HOLD; err_d = ERR_TIMEOUT;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          state_d = HUNT;
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_d = BODY; len_d = '0; clr_buf = 1'b1;
          end
        end else if (rx_valid) begin
          drop_inc = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= HUNT;
      err_q      <= ERR_NONE;
      len_q      <= '0;
      buf_q      <= '0;
      drop_count <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      len_q   <= len_d;
      if (clr_buf) buf_q <= '0;
      else begin
        if (we0) buf_q[idx0] <= b0;
        if (we1) buf_q[idx1] <= rx_data;
      end
      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  assign frame_valid = (state_q == HOLD);
  assign frame_data  = buf_q;
  assign frame_len   = len_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: expected frames are queued as bytes are
// driven and checked by a monitor when each frame is handshaken.
module tb_uart_rx_framer;

  localparam int MAXB = 32;
  localparam int TMO  = 200;

  typedef struct {
    logic [5:0]   len;
    logic [1:0]   err;
    logic [255:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_break = 1'b0;
  logic         frame_valid;
  logic         frame_ready = 1'b1;
  logic [255:0] frame_data;
  logic [5:0]   frame_len;
  logic [1:0]   frame_err;
  logic [7:0]   drop_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  uart_rx_framer #(.MAX_BYTES(MAXB), .SYNC_BYTE(8'hAA), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_break    (rx_break),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_len   (frame_len),
    .frame_err   (frame_err),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] pack(input string s);
    logic [255:0] d = '0;
    for (int i = 0; i < s.len(); i++) d[255-8*i -: 8] = s[i];
    return d;
  endfunction

  function automatic exp_t mk(input int len, input int err, input string s);
    exp_t e;
    e.len = 6'(len); e.err = 2'(err); e.data = pack(s);
    return e;
  endfunction

  // Monitor: every accepted frame is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resetn && frame_valid && frame_ready) begin
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: frame len=%0d err=%0d arrived, none expected", frame_len, frame_err);
      end else begin
        e = sb.pop_front();
        n_cmp += 2;
        if (frame_len !== e.len) begin
          n_bad++; $display("FAIL sb_len: got %0d want %0d", frame_len, e.len);
        end
        if (frame_err !== e.err) begin
          n_bad++; $display("FAIL sb_err: got %0d want %0d", frame_err, e.err);
        end
        if (frame_data !== e.data) begin
          n_bad++; $display("FAIL sb_data: got %h want %h", frame_data, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_cmp += 5;
    if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", frame_valid); end
    if (frame_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", frame_data); end
    if (frame_len !== 6'd0) begin n_bad++; $display("FAIL rst_len: got %0d want 0", frame_len); end
    if (frame_err !== 2'd0) begin n_bad++; $display("FAIL rst_err: got %0d want 0", frame_err); end
    if (drop_count !== 8'd0) begin n_bad++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_basic;
    sb.push_back(mk(2, 0, "hi"));
    send_str("\252hi\015");
    n_cmp++;
    if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early: got %b want 0", frame_valid); end
    send_byte(8'h0A);
    n_cmp++;
    if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency: got %b want 1", frame_valid); end
    idle(2);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL basic_drain: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_hunt;
    send_str("\125\101");
    rx_break = 1'b1; @(posedge clk); #1; rx_break = 1'b0;
    n_cmp++;
    if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL hunt_ignore: got %b want 0", frame_valid); end
    sb.push_back(mk(0, 0, ""));
    send_str("\252\015\012");
    idle(2);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL hunt_drain: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_overflow;
    string s = "";
    for (int i = 0; i < MAXB; i++) s = {s, "A"};
    frame_ready = 1'b0;
    sb.push_back(mk(32, 1, s));
    send_byte(8'hAA);
    for (int i = 0; i < MAXB + 1; i++) send_byte(8'h41);
    n_cmp += 3;
    if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid: got %b want 1", frame_valid); end
    if (frame_len !== 6'd32) begin n_bad++; $display("FAIL ovf_len: got %0d want 32", frame_len); end
    if (frame_err !== 2'd1) begin n_bad++; $display("FAIL ovf_err: got %0d want 1", frame_err); end
    send_str("\102\252\103");
    n_cmp += 2;
    if (drop_count !== 8'd3) begin n_bad++; $display("FAIL ovf_drop: got %0d want 3", drop_count); end
    if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_held: got %b want 1", frame_valid); end
    frame_ready = 1'b1;
    idle(2);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL ovf_drain: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_timeout_break;
    sb.push_back(mk(1, 2, "a"));
    send_str("\252a");
    idle(TMO - 1);
    n_cmp++;
    if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %b want 0", frame_valid); end
    idle(1);
    n_cmp++;
    if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL tmo_fire: got %b want 1", frame_valid); end
    idle(2);
    sb.push_back(mk(2, 3, "ab"));
    send_str("\252ab");
    rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h63;
    @(posedge clk); #1;
    rx_break = 1'b0; rx_valid = 1'b0;
    n_cmp++;
    if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL brk_valid: got %b want 1", frame_valid); end
    idle(2);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL tmo_drain: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_back_to_back;
    frame_ready = 1'b0;
    sb.push_back(mk(3, 0, "x\015y"));
    send_str("\252x\015y\015\012");
    n_cmp++;
    if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", frame_valid); end
    sb.push_back(mk(1, 0, "z"));
    frame_ready = 1'b1;
    send_byte(8'hAA);
    send_str("z\015\012");
    sb.push_back(mk(1, 0, "\015"));
    send_str("\252\015\015\012");
    idle(2);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_drain: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_reset_mid;
    send_str("\252q");
    resetn = 1'b0; #1;
    test_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(1);
    sb.push_back(mk(1, 0, "\012"));
    send_str("\252\012\015\012");
    idle(2);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL rstmid_drain: %0d pending want 0", sb.size()); end
  endtask

  initial begin
    idle(3);
    resetn = 1'b1;
    idle(1);
    test_reset();
    test_basic();
    test_hunt();
    test_overflow();
    test_timeout_break();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
